act_lut_arbiter: RTL
====================

Name: act_lut_arbiter

Overview:
Shared activation unit for the NU_COUNT neural units. Each NU presents a Q4.12 accumulator value and an activation select. A round-robin arbiter grants one request per cycle into a 3-stage pipeline that applies identity, ReLU or a piecewise-linear LUT function y = A*x + B. The coefficient LUT is written by the host/config path, and config writes take priority over lookups.

Parameters:
NU_COUNT, 4, number of requesting neural units
Q_SIZE, 16, data width; Q4.12 signed (Q_INT=4, Q_FRAC=12)
ACT_MASK_SIZE, 2, activation select width
ACT_LUT_DEPTH, 6, LUT address width (64 entries)
ACT_LUT_SIZE, 32, LUT entry width: [31:16] = A (Q4.12), [15:0] = B (Q4.12)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NU_COUNT  per-NU request valid
req_ready  out  NU_COUNT  one-hot grant (combinational)
req_x  in  NU_COUNT*Q_SIZE  packed inputs; NU i at [i*Q_SIZE +: Q_SIZE]
req_sel  in  NU_COUNT*ACT_MASK_SIZE  packed selects: 00 identity, 01 ReLU, 10 LUT PWL, 11 identity
cfg_we  in  1  LUT write enable
cfg_addr  in  ACT_LUT_DEPTH  LUT write address
cfg_data  in  ACT_LUT_SIZE  LUT write data
rsp_valid  out  1  result valid, single cycle per result
rsp_id  out  clog2(NU_COUNT)  index of the NU the result belongs to
rsp_y  out  Q_SIZE  result, Q4.12
busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (rst_n low at posedge):
  - RR pointer = 0; all stage valids = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_y = 0, busy = 0.
  - LUT contents are not reset; they are undefined until written.
  - Reset mid-operation discards all in-flight requests. No response for them appears after reset is released.
- Arbitration (combinational):
  - If cfg_we = 1, req_ready = 0 for all NUs.
  - Otherwise grant the first i with req_valid[i] = 1, searching ptr, ptr+1, ... mod NU_COUNT.
  - At most one req_ready bit is high. req_ready[i] never rises without req_valid[i].
  - On a grant to i, ptr <= (i+1) mod NU_COUNT. With no grant, ptr holds.
- Handshake: a request is accepted at a posedge where req_valid[i] & req_ready[i] = 1. An NU holds req_x and req_sel stable until accepted. There is no response backpressure; NUs always accept rsp.
- Config write: at the posedge with cfg_we = 1, LUT[cfg_addr] <= cfg_data. A lookup accepted in the following cycle sees the new data. No read and write occur in the same cycle by construction.
- Pipeline: fully pipelined, one accept per cycle.
  - Edge k (accept): S1 <= {valid, id, x, sel}; LUT registered read at index x[15:10], raw bits, unsigned.
  - Edge k+1: S2 <= {valid, id, x, sel, B, P = A*x}, with P a 32-bit signed product.
  - Edge k+2: rsp_valid/rsp_id/rsp_y registered.
  - Latency: rsp_valid high in the cycle after edge k+2, i.e. 3 cycles.
  - Back-to-back accepts give back-to-back responses, in accept order.
  - When rsp_valid = 0, rsp_y and rsp_id hold their last values.
- Arithmetic:
  - Identity: y = x.
  - ReLU: y = x[15] ? 0 : x.
  - PWL:
    - s = (P >>> 12), arithmetic shift (floor), kept to 21 bits.
    - t = s + sign-extended B.
    - y = saturate(t) to [0x8000, 0x7FFF].
  - No rounding.
- busy = OR of S1, S2 and output valids.
- Starvation bound: a continuously valid request is granted within NU_COUNT grant cycles. Cycles blocked by cfg_we are excluded.

Test Plan:
- Write LUT[1] = 0x1000_0800 (A = 1.0, B = 0.5); NU0 requests x = 0x0400 with sel = 10 -> after 3 cycles rsp_valid = 1, rsp_id = 0, rsp_y = 0x0C00.
- Saturation:
  - LUT[4] = 0x7FFF_4000; x = 0x1000, sel = 10 -> rsp_y = 0x7FFF.
  - LUT[60] = 0x7FFF_8000; x = 0xF000 -> rsp_y = 0x8000.
- All four NUs hold req_valid continuously from reset, sel = 00, x = 0x0100*(i+1) -> grants 0,1,2,3,0,... one per cycle; rsp_id follows the same order with 3-cycle lag; each rsp_y matches its x.
- ReLU: x = 0xF800 -> 0x0000; x = 0x0123 -> 0x0123; sel = 11 with x = 0xF800 -> 0xF800.
- cfg_we = 1 while NU1 and NU2 request with ptr = 1 -> req_ready = 0000 that cycle, ptr unchanged. Next cycle NU1 is granted, and a lookup at the just-written address returns the new coefficients.
- Fill the pipeline with 3 requests, then assert rst_n = 0 for one cycle -> rsp_valid = 0 and busy = 0 after the reset edge. No stale response follows. The next grant goes to NU0.

Source files
------------

// File: rtl/act_lut_arbiter.sv
// Shared activation unit: round-robin arbitration of NU requests into a 3-stage
// identity / ReLU / piecewise-linear (y = A*x + B) pipeline with a host-written LUT.
module act_lut_arbiter #(
    parameter int NU_COUNT      = 4,
    parameter int Q_SIZE        = 16,
    parameter int Q_FRAC        = 12,
    parameter int ACT_MASK_SIZE = 2,
    parameter int ACT_LUT_DEPTH = 6,
    parameter int ACT_LUT_SIZE  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NU_COUNT-1:0]               req_valid,
    output logic [NU_COUNT-1:0]               req_ready,
    input  logic [NU_COUNT*Q_SIZE-1:0]        req_x,
    input  logic [NU_COUNT*ACT_MASK_SIZE-1:0] req_sel,
    input  logic                              cfg_we,
    input  logic [ACT_LUT_DEPTH-1:0]          cfg_addr,
    input  logic [ACT_LUT_SIZE-1:0]           cfg_data,
    output logic                              rsp_valid,
    output logic [$clog2(NU_COUNT)-1:0]       rsp_id,
    output logic [Q_SIZE-1:0]                 rsp_y,
    output logic                              busy
);

    localparam int ID_W  = $clog2(NU_COUNT);
    localparam int P_W   = 2 * Q_SIZE;
    localparam int S_W   = P_W - Q_FRAC + 1;
    localparam int LUT_N = 1 << ACT_LUT_DEPTH;

    localparam logic [ACT_MASK_SIZE-1:0] SEL_RELU = ACT_MASK_SIZE'(1);
    localparam logic [ACT_MASK_SIZE-1:0] SEL_PWL  = ACT_MASK_SIZE'(2);

    localparam logic signed [S_W-1:0] T_MAX = S_W'((1 << (Q_SIZE - 1)) - 1);
    localparam logic signed [S_W-1:0] T_MIN = ~T_MAX;

    logic [ID_W-1:0]          ptr;
    logic [ID_W-1:0]          cand;
    logic [ID_W-1:0]          grant_id;
    logic                     grant_any;
    logic [Q_SIZE-1:0]        grant_x;
    logic [ACT_MASK_SIZE-1:0] grant_sel;

    logic [ACT_LUT_SIZE-1:0]  lut [LUT_N];
    logic [ACT_LUT_SIZE-1:0]  lut_q;
    logic signed [Q_SIZE-1:0] lut_a;

    logic                     s1_valid;
    logic [ID_W-1:0]          s1_id;
    logic signed [Q_SIZE-1:0] s1_x;
    logic [ACT_MASK_SIZE-1:0] s1_sel;

    logic                     s2_valid;
    logic [ID_W-1:0]          s2_id;
    logic [Q_SIZE-1:0]        s2_x;
    logic [ACT_MASK_SIZE-1:0] s2_sel;
    logic signed [Q_SIZE-1:0] s2_b;
    logic signed [P_W-1:0]    s2_p;

    logic signed [S_W-1:0]    s_shift;
    logic signed [S_W-1:0]    t_sum;
    logic [Q_SIZE-1:0]        pwl_y;
    logic [Q_SIZE-1:0]        y_next;

    // Config writes own the cycle, so no LUT read ever collides with a write.
    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path can infer a latch.
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (!cfg_we) begin
            for (int off = 0; off < NU_COUNT; off++) begin
                cand = ID_W'((int'(ptr) + off) % NU_COUNT);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        grant_x   = '0;
        grant_sel = '0;
        for (int i = 0; i < NU_COUNT; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_x   = req_x[i*Q_SIZE +: Q_SIZE];
                grant_sel = req_sel[i*ACT_MASK_SIZE +: ACT_MASK_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
        end else begin
            if (grant_any) ptr <= (grant_id == ID_W'(NU_COUNT - 1)) ? '0 : grant_id + 1'b1;
            s1_valid  <= grant_any;
            s2_valid  <= s1_valid;
            rsp_valid <= s2_valid;
            if (s2_valid) begin
                rsp_id <= s2_id;
                rsp_y  <= y_next;
            end
        end
    end

    // NOTE: the LUT and payload registers carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
        if (cfg_we) lut[cfg_addr] <= cfg_data;
        lut_q <= lut[grant_x[Q_SIZE-1 -: ACT_LUT_DEPTH]];
    end

    assign lut_a = lut_q[ACT_LUT_SIZE-1 -: Q_SIZE];

    always_ff @(posedge clk) begin
        s1_id  <= grant_id;
        s1_x   <= grant_x;
        s1_sel <= grant_sel;
        s2_id  <= s1_id;
        s2_x   <= s1_x;
        s2_sel <= s1_sel;
        s2_b   <= lut_q[Q_SIZE-1:0];
        s2_p   <= lut_a * s1_x;
    end

    // Floor-shift the product back to Q4.12, add B and clamp to the signed range.
    always_comb begin
        s_shift = S_W'(s2_p >>> Q_FRAC);
        t_sum   = s_shift + S_W'(s2_b);
        if (t_sum > T_MAX)      pwl_y = {1'b0, {(Q_SIZE-1){1'b1}}};
        else if (t_sum < T_MIN) pwl_y = {1'b1, {(Q_SIZE-1){1'b0}}};
        else                    pwl_y = t_sum[Q_SIZE-1:0];
        case (s2_sel)
            SEL_RELU: y_next = s2_x[Q_SIZE-1] ? '0 : s2_x;
            SEL_PWL:  y_next = pwl_y;
            default:  y_next = s2_x;
        endcase
    end

    assign busy = s1_valid | s2_valid | rsp_valid;

endmodule
